// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ISA opcodes, ALU functions.
package ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned ALU_W    = 3;

  // Debug-visible state encoding; values are exported on the State port.
  typedef enum logic [STATE_W-1:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_LOAD_A = 4'd3,
    ST_LOAD_B = 4'd4,
    ST_STORE  = 4'd5,
    ST_ADD    = 4'd6,
    ST_SUB    = 4'd7,
    ST_HALT   = 4'd8,
    ST_NOOP   = 4'd9
  } state_t;

  // Defined opcodes; every other value executes as a no-op.
  typedef enum logic [OPCODE_W-1:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  localparam logic [ALU_W-1:0] ALU_PASS = 3'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;

  // Map DECODE onto the execute state selected by the opcode.
  function automatic state_t exec_state(input logic [OPCODE_W-1:0] op);
    state_t st;
    case (op)
      OP_STORE: st = ST_STORE;
      OP_LOAD:  st = ST_LOAD_A;
      OP_ADD:   st = ST_ADD;
      OP_SUB:   st = ST_SUB;
      OP_HALT:  st = ST_HALT;
      default:  st = ST_NOOP;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous clear has priority over increment; wraps modulo 2^W.
module pc_reg #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] pc
);

  // Counter register; natural overflow provides the wrap to zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + W'(1);
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle controller: holds PC and IR, fetches from a combinational ROM and
// sequences the datapath control signals with a Moore FSM.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned PC_W      = 7,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned D_ADDR_W  = 8,
  parameter int unsigned RF_ADDR_W = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [INSTR_W-1:0]   Instr,
  output logic [PC_W-1:0]      PC_Addr,
  output logic [D_ADDR_W-1:0]  D_Addr,
  output logic                 D_Wr,
  output logic                 RF_s,
  output logic [RF_ADDR_W-1:0] RF_W_Addr,
  output logic                 RF_W_en,
  output logic [RF_ADDR_W-1:0] RF_Ra_Addr,
  output logic [RF_ADDR_W-1:0] RF_Rb_Addr,
  output logic [2:0]           ALU_s0,
  output logic [3:0]           State,
  output logic                 Halted
);

  state_t               state, state_d;
  logic [INSTR_W-1:0]   ir, ir_d;

  // Control outputs are registered from the decode of the upcoming state and IR,
  // so each output is a pure function of the current state and IR register.
  logic [D_ADDR_W-1:0]  d_addr_d;
  logic                 d_wr_d;
  logic                 rf_s_d;
  logic [RF_ADDR_W-1:0] rf_w_addr_d;
  logic                 rf_w_en_d;
  logic [RF_ADDR_W-1:0] rf_ra_addr_d;
  logic [RF_ADDR_W-1:0] rf_rb_addr_d;
  logic [2:0]           alu_s0_d;
  logic                 halted_d;

  logic                 pc_clr;
  logic                 pc_inc;

  assign pc_clr = Reset || (state == ST_INIT);
  assign pc_inc = (state == ST_FETCH);

  pc_reg #(
    .W (PC_W)
  ) u_pc_reg (
    .clk (Clk),
    .clr (pc_clr),
    .inc (pc_inc),
    .pc  (PC_Addr)
  );

  assign State = state;

  // State, IR and registered control outputs; reset returns to INIT with all controls low.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_INIT;
      ir         <= '0;
      D_Addr     <= '0;
      D_Wr       <= 1'b0;
      RF_s       <= 1'b0;
      RF_W_Addr  <= '0;
      RF_W_en    <= 1'b0;
      RF_Ra_Addr <= '0;
      RF_Rb_Addr <= '0;
      ALU_s0     <= ALU_PASS;
      Halted     <= 1'b0;
    end else begin
      state      <= state_d;
      ir         <= ir_d;
      D_Addr     <= d_addr_d;
      D_Wr       <= d_wr_d;
      RF_s       <= rf_s_d;
      RF_W_Addr  <= rf_w_addr_d;
      RF_W_en    <= rf_w_en_d;
      RF_Ra_Addr <= rf_ra_addr_d;
      RF_Rb_Addr <= rf_rb_addr_d;
      ALU_s0     <= alu_s0_d;
      Halted     <= halted_d;
    end
  end

  // Next-state, next-IR and output decode for the state being entered.
  always_comb begin
    state_d      = state;
    ir_d         = ir;
    d_addr_d     = '0;
    d_wr_d       = 1'b0;
    rf_s_d       = 1'b0;
    rf_w_addr_d  = '0;
    rf_w_en_d    = 1'b0;
    rf_ra_addr_d = '0;
    rf_rb_addr_d = '0;
    alu_s0_d     = ALU_PASS;
    halted_d     = 1'b0;

    case (state)
      ST_INIT: begin
        state_d = ST_FETCH;
        ir_d    = '0;
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
        ir_d    = Instr;
      end
      ST_DECODE: state_d = exec_state(ir[INSTR_W-1 -: OPCODE_W]);
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB, ST_NOOP: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_INIT;
    endcase

    case (state_d)
      ST_LOAD_A: begin
        d_addr_d    = D_ADDR_W'(ir_d[11:4]);
        rf_s_d      = 1'b1;
        rf_w_addr_d = RF_ADDR_W'(ir_d[3:0]);
      end
      ST_LOAD_B: begin
        d_addr_d    = D_ADDR_W'(ir_d[11:4]);
        rf_s_d      = 1'b1;
        rf_w_addr_d = RF_ADDR_W'(ir_d[3:0]);
        rf_w_en_d   = 1'b1;
      end
      ST_STORE: begin
        d_addr_d     = D_ADDR_W'(ir_d[11:4]);
        rf_ra_addr_d = RF_ADDR_W'(ir_d[3:0]);
        d_wr_d       = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        rf_ra_addr_d = RF_ADDR_W'(ir_d[11:8]);
        rf_rb_addr_d = RF_ADDR_W'(ir_d[7:4]);
        rf_w_addr_d  = RF_ADDR_W'(ir_d[3:0]);
        rf_w_en_d    = 1'b1;
        alu_s0_d     = (state_d == ST_ADD) ? ALU_ADD : ALU_SUB;
      end
      ST_HALT: halted_d = 1'b1;
      default: ;
    endcase
  end

endmodule
